// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  // Owner-id width for n requesters, never less than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [N-1:0] rot;
  logic         found;

  always_comb begin
    // rot[i] is the request at position (ptr + i) mod N.
    rot   = N'({req, req} >> ptr);
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        idx   = IW'((32'(ptr) + i) % N);
        gnt   = N'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB master port between NUM_REQ requesters,
// with SETUP/ACCESS sequencing, optional pready watchdog and per-owner response.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                          pclk_i,
  input  logic                          preset_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [WIDTH-1:0]              rsp_rdata_o,
  output logic                          rsp_err_o,
  output logic                          psel_o,
  output logic                          penable_o,
  output logic                          pwrite_o,
  output logic [ADDR_WIDTH-1:0]         paddr_o,
  output logic [WIDTH-1:0]              pwdata_o,
  input  logic [WIDTH-1:0]              prdata_i,
  input  logic                          pready_i,
  input  logic                          pslverr_i
);

  localparam int unsigned IW = id_width(NUM_REQ);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                  state, state_nx;
  logic [NUM_REQ-1:0]      gnt;
  logic [IW-1:0]           gnt_idx, ptr, owner;
  logic                    write_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [WIDTH-1:0]        wdata_q;
  logic [TW-1:0]           tcnt;
  logic                    psel_q, penable_q, psel_d, penable_d;
  logic                    accept, done, timeout_hit;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req (req_valid_i),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign timeout_hit = (TIMEOUT != 0) && !pready_i && (32'(tcnt) == TIMEOUT - 1);
  assign accept      = (state == IDLE) && (|req_valid_i);
  assign done        = (state == ACCESS) && (pready_i || timeout_hit);

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req_valid_i) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (pready_i || timeout_hit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grant is masked during reset so all outputs read 0 while preset_i is high.
  always_comb begin
    req_ready_o = '0;
    if (state == IDLE && !preset_i) req_ready_o = gnt;
    psel_d    = (state_nx != IDLE);
    penable_d = (state_nx == ACCESS);
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner       <= '0;
      ptr         <= '0;
      tcnt        <= '0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      if (accept) begin
        write_q <= req_write_i[gnt_idx];
        addr_q  <= req_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_q <= req_wdata_i[gnt_idx*WIDTH +: WIDTH];
        owner   <= gnt_idx;
      end
      if (state == ACCESS) tcnt <= done ? '0 : tcnt + 1'b1;
      if (done) begin
        rsp_valid_o <= NUM_REQ'(1) << owner;
        rsp_err_o   <= pready_i ? pslverr_i : 1'b1;
        rsp_rdata_o <= (pready_i && !write_q) ? prdata_i : '0;
        ptr         <= (32'(owner) + 1 == NUM_REQ) ? '0 : owner + 1'b1;
      end
    end
  end

  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = write_q;
  assign paddr_o   = addr_q;
  assign pwdata_o  = wdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed vector table,
// multi-cycle corner sequences and randomized traffic against a transaction model.
module tb_apb_master_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic            pclk = 1'b0;
  logic            preset = 1'b0;
  logic [N-1:0]    req_valid = '0, req_ready, req_write = '0, rsp_valid;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [DW-1:0]   rsp_rdata, pwdata, prdata = '0;
  logic            rsp_err, psel, penable, pwrite;
  logic [AW-1:0]   paddr;
  logic            pready = 1'b0, pslverr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          k;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic        serr;
    logic [31:0] prd;
    logic [3:0]  exp_rsp;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  apb_master_arbiter #(
    .NUM_REQ    (N),
    .ADDR_WIDTH (AW),
    .WIDTH      (DW),
    .TIMEOUT    (TO)
  ) dut (
    .pclk_i      (pclk),
    .preset_i    (preset),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .psel_o      (psel),
    .penable_o   (penable),
    .pwrite_o    (pwrite),
    .paddr_o     (paddr),
    .pwdata_o    (pwdata),
    .prdata_i    (prdata),
    .pready_i    (pready),
    .pslverr_i   (pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[k]           = wr;
    req_addr[k*AW +: AW]   = a;
    req_wdata[k*DW +: DW]  = d;
    req_valid[k]           = 1'b1;
  endtask

  // Reference arbitration: first valid requester at or after pointer p, wrapping.
  function automatic int rr_pick(input int p, input logic [N-1:0] v);
    for (int i = 0; i < int'(N); i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  // Called in an IDLE cycle with requests driven; runs one full transfer and
  // returns in the cycle that carries the response pulse.
  task automatic do_xfer(input string tag, input int k, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int waits, input logic serr,
                         input logic [DW-1:0] prd, input logic [N-1:0] exp_oh,
                         input logic [DW-1:0] exp_rdata, input logic exp_err, input bit drop);
    int nacc;
    #1;
    check({tag, " grant"}, req_ready, exp_oh);
    tick();
    if (drop) req_valid[k] = 1'b0;
    check({tag, " setup psel/penable"}, {psel, penable}, 2'b10);
    check({tag, " setup paddr"}, paddr, a);
    check({tag, " setup pwrite"}, pwrite, wr);
    if (wr) check({tag, " setup pwdata"}, pwdata, d);
    check({tag, " setup ready"}, req_ready, 0);
    check({tag, " setup rsp_valid"}, rsp_valid, 0);
    tick();
    nacc = (waits >= int'(TO)) ? int'(TO) : waits + 1;
    for (int j = 0; j < nacc; j++) begin
      if (j == nacc - 1 && waits < int'(TO)) begin
        pready = 1'b1; pslverr = serr; prdata = prd;
      end else begin
        pready = 1'b0; pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
      end
      check({tag, " access psel/penable"}, {psel, penable}, 2'b11);
      check({tag, " access paddr"}, paddr, a);
      check({tag, " access pwrite"}, pwrite, wr);
      check({tag, " access rsp_valid"}, rsp_valid, 0);
      check({tag, " access ready"}, req_ready, 0);
      tick();
    end
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    check({tag, " rsp_valid"}, rsp_valid, exp_oh);
    check({tag, " rsp_rdata"}, rsp_rdata, exp_rdata);
    check({tag, " rsp_err"}, rsp_err, exp_err);
    check({tag, " end psel/penable"}, {psel, penable}, 2'b00);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int ptr_m, w, waits, nacc_dummy;
    logic wr, serr, tmo;
    logic [AW-1:0] a;
    logic [DW-1:0] d, prd;

    vecs[0] = '{2, 1'b1, 8'h10, 32'hDEADBEEF, 0,  1'b0, 32'h0,        4'b0100, 32'h0,        1'b0};
    vecs[1] = '{0, 1'b0, 8'h04, 32'h0,        3,  1'b0, 32'h12345678, 4'b0001, 32'h12345678, 1'b0};
    vecs[2] = '{1, 1'b1, 8'h20, 32'hA5A5A5A5, 0,  1'b1, 32'hFFFFFFFF, 4'b0010, 32'h0,        1'b1};
    vecs[3] = '{3, 1'b0, 8'h3C, 32'h0,        20, 1'b0, 32'h55AA55AA, 4'b1000, 32'h0,        1'b1};
    vecs[4] = '{1, 1'b0, 8'h80, 32'h0,        1,  1'b1, 32'hCAFE0001, 4'b0010, 32'hCAFE0001, 1'b1};
    vecs[5] = '{3, 1'b1, 8'h7F, 32'h01234567, 2,  1'b0, 32'h89ABCDEF, 4'b1000, 32'h0,        1'b0};
    vecs[6] = '{0, 1'b0, 8'hFF, 32'h0,        15, 1'b0, 32'h0BADF00D, 4'b0001, 32'h0BADF00D, 1'b0};
    nacc_dummy = 0;

    // Reset state, with every requester asserting valid.
    req_valid = '1;
    #1 preset = 1'b1;
    #2;
    check("reset ready", req_ready, 0);
    check("reset psel/penable", {psel, penable}, 2'b00);
    check("reset rsp", {rsp_valid, rsp_err}, 0);
    check("reset rdata", rsp_rdata, 0);
    check("reset apb payload", {pwrite, paddr, pwdata}, 0);
    tick();
    tick();
    req_valid = '0;
    preset = 1'b0;
    #1;
    check("idle no request ready", req_ready, 0);

    // Directed vector table.
    foreach (vecs[i]) begin
      req_valid = '0;
      set_req(vecs[i].k, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      do_xfer($sformatf("vec%0d", i), vecs[i].k, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].waits, vecs[i].serr, vecs[i].prd, vecs[i].exp_rsp,
              vecs[i].exp_rdata, vecs[i].exp_err, 1'b1);
    end

    // All four held valid from reset: grants rotate 0,1,2,3,0,1,2,3.
    preset = 1'b1;
    tick();
    preset = 1'b0;
    req_valid = '0;
    for (int k = 0; k < int'(N); k++) set_req(k, 1'(k % 2), 8'(k * 4 + 1), 32'(k) * 32'h01010101);
    for (int i = 0; i < 8; i++) begin
      w = i % int'(N);
      do_xfer($sformatf("rr%0d", i), w, 1'(w % 2), 8'(w * 4 + 1), 32'(w) * 32'h01010101, 0, 1'b0,
              32'h11110000 + 32'(i), N'(1) << w, (w % 2 == 1) ? 32'h0 : 32'h11110000 + 32'(i),
              1'b0, 1'b0);
    end

    // Reset in the middle of ACCESS abandons the transfer.
    req_valid = '0;
    set_req(1, 1'b0, 8'h44, 32'h0);
    #1;
    check("rst-mid grant", req_ready, 4'b0010);
    tick();
    req_valid[1] = 1'b0;
    tick();
    set_req(0, 1'b1, 8'h0A, 32'hFEEDFACE);
    set_req(3, 1'b0, 8'h3A, 32'h0);
    check("rst-mid in access", {psel, penable}, 2'b11);
    preset = 1'b1;
    #1;
    check("rst-mid psel/penable", {psel, penable}, 2'b00);
    check("rst-mid ready", req_ready, 0);
    tick();
    check("rst-mid no rsp", rsp_valid, 0);
    preset = 1'b0;
    do_xfer("post-rst tie", 0, 1'b1, 8'h0A, 32'hFEEDFACE, 0, 1'b0, 32'h0, 4'b0001, 32'h0, 1'b0, 1'b1);
    do_xfer("post-rst next", 3, 1'b0, 8'h3A, 32'h0, 1, 1'b0, 32'h600DCAFE, 4'b1000,
            32'h600DCAFE, 1'b0, 1'b1);

    // Randomized traffic against the transaction-level model.
    req_valid = '0;
    preset = 1'b1;
    tick();
    preset = 1'b0;
    ptr_m = 0;
    for (int t = 0; t < 60; t++) begin
      for (int g = 0; g < 8; g++) begin
        for (int k = 0; k < int'(N); k++) begin
          if (!req_valid[k] && $urandom_range(0, 2) == 0)
            set_req(k, 1'($urandom_range(0, 1)), 8'($urandom), $urandom);
          else if (req_valid[k] && $urandom_range(0, 7) == 0)
            req_valid[k] = 1'b0;
        end
        if (g == 7 && req_valid == '0)
          set_req(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)), 8'($urandom), $urandom);
        if (req_valid != '0) break;
        #1;
        check("rand idle ready", req_ready, 0);
        tick();
      end
      w     = rr_pick(ptr_m, req_valid);
      wr    = req_write[w];
      a     = req_addr[w*AW +: AW];
      d     = req_wdata[w*DW +: DW];
      waits = int'($urandom_range(0, 11));
      if (waits > 7) waits = (waits == 11) ? int'(TO) + 2 : int'(TO) - 1;
      else           waits = waits % 4;
      serr  = 1'($urandom_range(0, 1));
      prd   = $urandom;
      tmo   = (waits >= int'(TO));
      do_xfer($sformatf("rand%0d", t), w, wr, a, d, waits, serr, prd, N'(1) << w,
              (tmo || wr) ? 32'h0 : prd, tmo ? 1'b1 : serr, 1'b1);
      ptr_m = (w + 1) % int'(N);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
